generic_bus_arbiter: RTL

GENERIC_BUS_ARBITER -- requirements
Module: generic_bus_arbiter

---
 rtl/generic_bus_arbiter_if.sv | 66 ++++++
 rtl/generic_bus_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/generic_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : generic_bus_arbiter_if
//  Purpose  : Bundles the manager-side and subordinate-side bus signals of
//             generic_bus_arbiter. Manager-side vectors are packed, with
//             slice i belonging to manager i.
//  Modports : master - arbiter view (drives s_* requests and m_* responses)
//             slave  - environment view (managers plus subordinate model)
//  Revision : 1.0 - initial release
// ============================================================================
interface generic_bus_arbiter_if #(
    parameter int NumMgrs   = 2,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int ProtWidth = 4
);
    // manager request side
    logic [NumMgrs-1:0]               m_wEn;
    logic [NumMgrs-1:0]               m_rEn;
    logic [NumMgrs-1:0]               m_isBurst;
    logic [NumMgrs-1:0]               m_nonSec;
    logic [NumMgrs*AddrWidth-1:0]     m_addr;
    logic [NumMgrs*DataWidth-1:0]     m_wData;
    logic [NumMgrs*(DataWidth/8)-1:0] m_wStrb;
    logic [NumMgrs*2-1:0]             m_burstType;
    logic [NumMgrs*8-1:0]             m_burstLen;
    logic [NumMgrs*ProtWidth-1:0]     m_prot;
    // manager response side
    logic [NumMgrs*DataWidth-1:0]     m_rData;
    logic [NumMgrs-1:0]               m_busy;
    logic [NumMgrs-1:0]               m_error;
    // subordinate request side
    logic                             s_wEn;
    logic                             s_rEn;
    logic [AddrWidth-1:0]             s_addr;
    logic [DataWidth-1:0]             s_wData;
    logic [DataWidth/8-1:0]           s_wStrb;
    logic                             s_isBurst;
    logic [1:0]                       s_burstType;
    logic [7:0]                       s_burstLen;
    logic                             s_nonSec;
    logic [ProtWidth-1:0]             s_prot;
    // subordinate response side
    logic [DataWidth-1:0]             s_rData;
    logic                             s_busy;
    logic                             s_error;

    modport master (
        input  m_wEn, m_rEn, m_isBurst, m_nonSec, m_addr, m_wData, m_wStrb,
               m_burstType, m_burstLen, m_prot,
        output m_rData, m_busy, m_error,
        output s_wEn, s_rEn, s_addr, s_wData, s_wStrb, s_isBurst,
               s_burstType, s_burstLen, s_nonSec, s_prot,
        input  s_rData, s_busy, s_error
    );

    modport slave (
        output m_wEn, m_rEn, m_isBurst, m_nonSec, m_addr, m_wData, m_wStrb,
               m_burstType, m_burstLen, m_prot,
        input  m_rData, m_busy, m_error,
        input  s_wEn, s_rEn, s_addr, s_wData, s_wStrb, s_isBurst,
               s_burstType, s_burstLen, s_nonSec, s_prot,
        output s_rData, s_busy, s_error
    );
endinterface
`default_nettype wire

// File: rtl/generic_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : generic_bus_arbiter
//  Purpose  : Round-robin arbiter granting one of NumMgrs managers access to
//             a single subordinate, with burst locking.
//  Ports    : clk    - clock, all state on rising edge
//             reset  - synchronous active-high reset
//             bus    - manager/subordinate signal bundle (master modport)
//             gnt    - one-hot grant vector (zero while idle)
//             locked - high while a burst tenure holds the bus
//  Revision : 1.0 - initial release
// ============================================================================
module generic_bus_arbiter #(
    parameter int NumMgrs   = 2,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int ProtWidth = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    generic_bus_arbiter_if.master    bus,
    output logic [NumMgrs-1:0]       gnt,
    output logic                     locked
);

    localparam int c_idx_w  = (NumMgrs > 1) ? $clog2(NumMgrs) : 1;
    localparam int c_strb_w = DataWidth / 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    logic [1:0]           r_state;
    logic [NumMgrs-1:0]   r_gnt;
    logic [c_idx_w-1:0]   r_gidx;      // binary index of the granted manager
    logic [c_idx_w-1:0]   r_rr_ptr;
    logic [7:0]           r_cnt;

    logic [NumMgrs-1:0]   w_req;
    logic                 w_found;
    logic [c_idx_w-1:0]   w_win;
    logic [c_idx_w-1:0]   w_rr_next;
    logic                 w_active;
    logic                 w_greq;
    logic                 w_beat;
    logic                 w_release;

    logic                 w_s_wEn;
    logic                 w_s_rEn;
    logic [AddrWidth-1:0] w_s_addr;
    logic [DataWidth-1:0] w_s_wData;
    logic [c_strb_w-1:0]  w_s_wStrb;
    logic                 w_s_isBurst;
    logic [1:0]           w_s_burstType;
    logic [7:0]           w_s_burstLen;
    logic                 w_s_nonSec;
    logic [ProtWidth-1:0] w_s_prot;

    logic [NumMgrs*DataWidth-1:0] w_m_rData;
    logic [NumMgrs-1:0]           w_m_busy;
    logic [NumMgrs-1:0]           w_m_error;

    assign w_req = bus.m_wEn | bus.m_rEn;

    // Bus is owned only outside IDLE; reset masks the routing immediately so
    // the subordinate never sees an access during the reset cycle.
    assign w_active  = (r_state != IDLE) && !reset;
    assign w_greq    = w_req[r_gidx];
    assign w_beat    = w_greq && !bus.s_busy;
    assign w_release = !w_greq && !bus.s_busy;

    // Round-robin search: first requester at or after r_rr_ptr, wrapping.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = 0; k < NumMgrs; k++) begin
            idx = (int'(r_rr_ptr) + k) % NumMgrs;
            if (!w_found && w_req[idx]) begin
                w_found = 1'b1;
                w_win   = idx[c_idx_w-1:0];
            end
        end
    end

    assign w_rr_next = (w_win == c_idx_w'(NumMgrs - 1)) ? '0 : w_win + 1'b1;

    // Route the granted manager's slice to the subordinate.
    always_comb begin
        w_s_wEn       = 1'b0;
        w_s_rEn       = 1'b0;
        w_s_addr      = '0;
        w_s_wData     = '0;
        w_s_wStrb     = '0;
        w_s_isBurst   = 1'b0;
        w_s_burstType = '0;
        w_s_burstLen  = '0;
        w_s_nonSec    = 1'b0;
        w_s_prot      = '0;
        if (w_active) begin
            w_s_wEn       = bus.m_wEn[r_gidx];
            w_s_rEn       = bus.m_rEn[r_gidx];
            w_s_addr      = bus.m_addr[r_gidx*AddrWidth +: AddrWidth];
            w_s_wData     = bus.m_wData[r_gidx*DataWidth +: DataWidth];
            w_s_wStrb     = bus.m_wStrb[r_gidx*c_strb_w +: c_strb_w];
            w_s_isBurst   = bus.m_isBurst[r_gidx];
            w_s_burstType = bus.m_burstType[r_gidx*2 +: 2];
            w_s_burstLen  = bus.m_burstLen[r_gidx*8 +: 8];
            w_s_nonSec    = bus.m_nonSec[r_gidx];
            w_s_prot      = bus.m_prot[r_gidx*ProtWidth +: ProtWidth];
        end
    end

    assign bus.s_wEn       = w_s_wEn;
    assign bus.s_rEn       = w_s_rEn;
    assign bus.s_addr      = w_s_addr;
    assign bus.s_wData     = w_s_wData;
    assign bus.s_wStrb     = w_s_wStrb;
    assign bus.s_isBurst   = w_s_isBurst;
    assign bus.s_burstType = w_s_burstType;
    assign bus.s_burstLen  = w_s_burstLen;
    assign bus.s_nonSec    = w_s_nonSec;
    assign bus.s_prot      = w_s_prot;

    // Responses: the owner sees the subordinate; everyone else is stalled
    // for as long as they request and sees zero data and no error.
    always_comb begin
        w_m_rData = '0;
        w_m_busy  = w_req;
        w_m_error = '0;
        for (int i = 0; i < NumMgrs; i++) begin
            if (w_active && (r_gidx == c_idx_w'(i))) begin
                w_m_rData[i*DataWidth +: DataWidth] = bus.s_rData;
                w_m_busy[i]  = bus.s_busy;
                w_m_error[i] = bus.s_error;
            end
        end
    end

    assign bus.m_rData = w_m_rData;
    assign bus.m_busy  = w_m_busy;
    assign bus.m_error = w_m_error;

    assign gnt    = r_gnt;
    assign locked = (r_state == BURST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_gidx   <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_gnt    <= {{(NumMgrs-1){1'b0}}, 1'b1} << w_win;
                        r_gidx   <= w_win;
                        r_rr_ptr <= w_rr_next;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                    end else if (w_beat) begin
                        // First beat of a clean burst locks the bus with
                        // burstLen beats still to go.
                        if (w_s_isBurst && (w_s_burstLen != 8'd0) && !bus.s_error) begin
                            r_state <= BURST;
                            r_cnt   <= w_s_burstLen;
                        end else begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                            r_cnt   <= '0;
                        end
                    end
                end
                BURST: begin
                    if (w_release) begin
                        r_state <= IDLE;
                        r_gnt   <= '0;
                        r_cnt   <= '0;
                    end else if (w_beat) begin
                        // A counter at 1 reaches 0 on this beat; <= also
                        // covers a zero counter so it can never underflow.
                        if (bus.s_error || (r_cnt <= 8'd1)) begin
                            r_state <= IDLE;
                            r_gnt   <= '0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
